// File: rtl/blit_video_if.sv
// Pixel-word and video bus between blit_disp, blit_video and the panel stage.
//   pixel_valid/pixel_data : framebuffer words from blit_disp (no backpressure)
//   dmahstart/vblank       : fetch strobes back to blit_disp
//   video_*                : serialized 1 bpp stream with DE/HSYNC/VSYNC
//   underrun/overflow      : FIFO error pulses
// master = word producer / video consumer side, slave = blit_video.
interface blit_video_if;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic        dmahstart;
  logic        vblank;
  logic        video_ce;
  logic        video_de;
  logic        video_hs;
  logic        video_vs;
  logic        video_pix;
  logic        underrun;
  logic        overflow;

  modport master (
    output pixel_valid, pixel_data,
    input  dmahstart, vblank, video_ce, video_de, video_hs, video_vs,
           video_pix, underrun, overflow
  );

  modport slave (
    input  pixel_valid, pixel_data,
    output dmahstart, vblank, video_ce, video_de, video_hs, video_vs,
           video_pix, underrun, overflow
  );
endinterface

// File: rtl/blit_video.sv
// blit_video: video timing generator and 1 bpp pixel serializer.
// Generates hcount/vcount from a divided pixel clock enable, requests each
// active line from blit_disp with dmahstart during the previous hblank,
// buffers the returned 16-bit words in a small FIFO and shifts them out
// MSB-first with DE/HS/VS. All outputs are registered one clk after the
// ce cycle that computed them.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : blit_video_if.slave (pixel words in, strobes and video out)
module blit_video #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 72,
  parameter int H_BP       = 96,
  parameter int V_ACTIVE   = 1024,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 7,
  parameter int V_BP       = 32,
  parameter int CLK_DIV    = 1,
  parameter int FIFO_DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  blit_video_if.slave  bus
);
  localparam int DATA_W  = 16;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  logic [DW-1:0]     div_q;
  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  logic [VW-1:0]     vcount_next;
  logic              ce, h_wrap, next_active, in_blank;
  logic              de_c, hs_c, vs_c, dma_c;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shifter;
  logic              fifo_empty, fifo_full, accept, push, pop_slot, pop, flush;
  logic              fetch_open;

  logic              vld_p1, de_p1, hs_p1, vs_p1, pix_p1;
  logic              und_p1, dma_p1, vblank_p1, ovf_p1;

  assign ce          = (div_q == '0);
  assign h_wrap      = (hcount == HW'(H_TOTAL - 1));
  assign vcount_next = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
  assign next_active = (vcount_next < VW'(V_ACTIVE));
  assign in_blank    = (vcount >= VW'(V_ACTIVE));
  assign de_c        = (hcount < HW'(H_ACTIVE)) && !in_blank;
  assign hs_c        = (hcount >= HW'(H_ACTIVE + H_FP)) &&
                       (hcount <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_c        = (vcount >= VW'(V_ACTIVE + V_FP)) &&
                       (vcount <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign dma_c       = ce && (hcount == HW'(H_ACTIVE - 1)) && next_active;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head        = mem[rd_ptr[AW-1:0]];

  // Words for line 0 are fetched during the last blank line, while vblank is
  // still high. Once that request has gone out, the FIFO accepts words even
  // though vblank is set; stray words earlier in the blank are discarded.
  assign accept      = !vblank_p1 || fetch_open;
  assign push        = bus.pixel_valid && accept && !fifo_full;
  assign pop_slot    = ce && de_c && (hcount[3:0] == 4'd0);
  assign pop         = pop_slot && !fifo_empty;
  // Clear the FIFO on the clk where vblank rises, resynchronising each frame.
  assign flush       = !vblank_p1 && in_blank;

  // Stage 0: pixel clock divider and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      hcount <= '0;
      vcount <= VW'(V_ACTIVE);
    end else begin
      div_q <= (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
      if (ce) begin
        hcount <= h_wrap ? '0 : hcount + 1'b1;
        if (h_wrap) vcount <= vcount_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fetch_open <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (dma_c && in_blank) fetch_open <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.pixel_data;
  end

  // Stage 1: registered video outputs, strobes and serializer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      de_p1     <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
      pix_p1    <= 1'b0;
      und_p1    <= 1'b0;
      dma_p1    <= 1'b0;
      ovf_p1    <= 1'b0;
      vblank_p1 <= 1'b1;
      shifter   <= '0;
    end else begin
      vld_p1    <= ce;
      und_p1    <= 1'b0;
      dma_p1    <= dma_c;
      vblank_p1 <= in_blank;
      ovf_p1    <= bus.pixel_valid && accept && fifo_full;
      if (ce) begin
        de_p1 <= de_c;
        hs_p1 <= hs_c;
        vs_p1 <= vs_c;
        if (!de_c) begin
          pix_p1 <= 1'b0;
        end else if (pop_slot) begin
          if (fifo_empty) begin
            // Missing word: blank the 16 pixels, keep raster timing.
            pix_p1  <= 1'b0;
            shifter <= '0;
            und_p1  <= 1'b1;
          end else begin
            pix_p1  <= head[DATA_W-1];
            shifter <= {head[DATA_W-2:0], 1'b0};
          end
        end else begin
          pix_p1  <= shifter[DATA_W-1];
          shifter <= {shifter[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.video_ce  = vld_p1;
  assign bus.video_de  = de_p1;
  assign bus.video_hs  = hs_p1;
  assign bus.video_vs  = vs_p1;
  assign bus.video_pix = pix_p1;
  assign bus.underrun  = und_p1;
  assign bus.dmahstart = dma_p1;
  assign bus.vblank    = vblank_p1;
  assign bus.overflow  = ovf_p1;
endmodule
